// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM for the convolution processor's fetch loop.
// Drives the program counter controls, captures each fetched instruction,
// resolves NOP/JMP/JZ/HALT locally and hands everything else to the
// datapath, then waits for its done pulse before advancing.
//
// Handshakes: instr_valid qualifies instr_in and is only honoured in FETCH.
// ir_valid is a one-cycle dispatch of ir; exec_done is a one-cycle return
// pulse that is only honoured in EXEC. pc_wen, pc_inc and ir_valid are
// one-cycle pulses and never coincide.
module fetch_sequencer #(
   parameter int ADDR_W  = 6,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  pc_addr,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               instr_valid,
   input  logic               zero_flag,
   input  logic               exec_done,
   output logic               pc_en,
   output logic               pc_wen,
   output logic               pc_inc,
   output logic [31:0]        pc_data,
   output logic               complete,
   output logic [INSTR_W-1:0] ir,
   output logic               ir_valid,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      FETCH  = 3'd2,
      DECODE = 3'd3,
      EXEC   = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t               state_q;
   state_t               state_d;
   logic                 pc_wen_d;
   logic                 pc_inc_d;
   logic [31:0]          pc_data_d;
   logic [INSTR_W-1:0]   ir_d;
   logic                 ir_valid_d;
   logic                 inc_req;
   logic                 jmp_req;
   logic                 at_top;
   logic [3:0]           opcode;

   assign opcode = ir[INSTR_W-1:INSTR_W-4];
   // Incrementing from the last address would wrap to 0; stop instead.
   assign at_top = (pc_addr == {ADDR_W{1'b1}});

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      pc_wen_d   = 1'b0;
      pc_inc_d   = 1'b0;
      pc_data_d  = pc_data;
      ir_d       = ir;
      ir_valid_d = 1'b0;
      inc_req    = 1'b0;
      jmp_req    = 1'b0;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d   = LOAD;
               pc_wen_d  = 1'b1;
               pc_data_d = 32'd0;
            end
         end
         LOAD: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (instr_valid) begin
               ir_d    = instr_in;
               state_d = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_NOP:  inc_req = 1'b1;
               OP_JMP:  jmp_req = 1'b1;
               OP_JZ: begin
                  if (zero_flag) begin
                     jmp_req = 1'b1;
                  end else begin
                     inc_req = 1'b1;
                  end
               end
               OP_HALT: state_d = HALT;
               default: begin
                  ir_valid_d = 1'b1;
                  state_d    = EXEC;
               end
            endcase
         end
         EXEC: begin
            if (exec_done) begin
               inc_req = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (jmp_req) begin
         pc_wen_d  = 1'b1;
         pc_data_d = {{(32-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
         state_d   = FETCH;
      end
      if (inc_req) begin
         if (at_top) begin
            state_d = HALT;
         end else begin
            pc_inc_d = 1'b1;
            state_d  = FETCH;
         end
      end
   end

   // Output registers, all derived from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_en    <= 1'b0;
         pc_wen   <= 1'b0;
         pc_inc   <= 1'b0;
         pc_data  <= 32'd0;
         complete <= 1'b0;
         ir       <= '0;
         ir_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         pc_en    <= (state_d != IDLE);
         pc_wen   <= pc_wen_d;
         pc_inc   <= pc_inc_d;
         pc_data  <= pc_data_d;
         complete <= (state_d == HALT);
         ir       <= ir_d;
         ir_valid <= ir_valid_d;
         busy     <= (state_d == LOAD) || (state_d == FETCH) ||
                     (state_d == DECODE) || (state_d == EXEC);
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  pc_addr;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        zero_flag;
   logic        exec_done;
   logic        pc_en;
   logic        pc_wen;
   logic        pc_inc;
   logic [31:0] pc_data;
   logic        complete;
   logic [31:0] ir;
   logic        ir_valid;
   logic        busy;

   int n_checks;
   int n_pass;

   fetch_sequencer #(.ADDR_W(6), .INSTR_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pc_addr     (pc_addr),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .zero_flag   (zero_flag),
      .exec_done   (exec_done),
      .pc_en       (pc_en),
      .pc_wen      (pc_wen),
      .pc_inc      (pc_inc),
      .pc_data     (pc_data),
      .complete    (complete),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .busy        (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   // single checking task
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock, then sample just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one instruction for a single FETCH cycle; leaves DUT in DECODE
   task automatic fetch(input logic [31:0] instr);
      instr_valid = 1'b1;
      instr_in    = instr;
      tick();
      instr_valid = 1'b0;
      instr_in    = 32'hDEAD_BEEF;
   endtask

   // control bits packed as {pc_en, pc_wen, pc_inc, complete, ir_valid, busy}
   function automatic logic [31:0] ctl();
      return {26'd0, pc_en, pc_wen, pc_inc, complete, ir_valid, busy};
   endfunction

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      pc_addr     = 6'd0;
      instr_in    = 32'd0;
      instr_valid = 1'b0;
      zero_flag   = 1'b0;
      exec_done   = 1'b0;

      // reset state
      tick();
      tick();
      check("rst_ctl", ctl(), 32'b000000);
      check("rst_pc_data", pc_data, 32'd0);
      check("rst_ir", ir, 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_ctl", ctl(), 32'b000000);

      // start -> LOAD with pc_wen and pc_data=0
      start = 1'b1;
      tick();
      start = 1'b0;
      check("load_ctl", ctl(), 32'b110001);
      check("load_pc_data", pc_data, 32'd0);
      tick();
      check("fetch_ctl", ctl(), 32'b100001);
      tick();
      check("fetch_hold_ctl", ctl(), 32'b100001);

      // NOP -> single pc_inc
      fetch(32'h0000_0000);
      check("nop_ir", ir, 32'h0000_0000);
      tick();
      check("nop_inc", ctl(), 32'b101001);
      tick();
      check("nop_inc_end", ctl(), 32'b100001);

      // datapath op -> dispatch, wait for exec_done
      pc_addr = 6'd1;
      fetch(32'h5000_0000);
      check("exe_ir", ir, 32'h5000_0000);
      tick();
      check("exe_dispatch", ctl(), 32'b100011);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("exe_wait", ctl(), 32'b100001);
      end
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      check("exe_done_inc", ctl(), 32'b101001);

      // JMP
      pc_addr = 6'd2;
      fetch(32'hA000_0015);
      check("jmp_pre", ctl(), 32'b100001);
      tick();
      check("jmp_wen", ctl(), 32'b110001);
      check("jmp_pc_data", pc_data, 32'h15);

      // JZ not taken
      pc_addr   = 6'h15;
      zero_flag = 1'b0;
      fetch(32'hB000_0003);
      tick();
      check("jz_nt", ctl(), 32'b101001);
      check("jz_nt_pc_data", pc_data, 32'h15);

      // JZ taken
      pc_addr   = 6'h16;
      zero_flag = 1'b1;
      fetch(32'hB000_0003);
      tick();
      zero_flag = 1'b0;
      check("jz_t", ctl(), 32'b110001);
      check("jz_t_pc_data", pc_data, 32'd3);

      // NOP at the last address -> HALT, no increment
      pc_addr = 6'h3F;
      fetch(32'h0000_0000);
      tick();
      check("wrap_halt", ctl(), 32'b100100);
      tick();
      check("wrap_hold", ctl(), 32'b100100);

      // spurious inputs in HALT are ignored
      exec_done   = 1'b1;
      instr_valid = 1'b1;
      instr_in    = 32'h5000_0000;
      tick();
      exec_done   = 1'b0;
      instr_valid = 1'b0;
      check("halt_spur_ctl", ctl(), 32'b100100);
      check("halt_spur_ir", ir, 32'h0000_0000);

      // restart from HALT
      pc_addr = 6'd0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      check("restart_ctl", ctl(), 32'b110001);
      check("restart_pc_data", pc_data, 32'd0);
      tick();

      // HALT opcode
      fetch(32'hF000_0000);
      tick();
      check("halt_op", ctl(), 32'b100100);
      check("halt_op_pc_data", pc_data, 32'd0);

      // reset during EXEC
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      pc_addr = 6'd4;
      fetch(32'h7000_0001);
      tick();
      check("pre_rst_dispatch", ctl(), 32'b100011);
      tick();
      rst_n = 1'b0;
      #1;
      check("async_rst_ctl", ctl(), 32'b000000);
      check("async_rst_ir", ir, 32'd0);
      tick();
      rst_n     = 1'b1;
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      check("post_rst_done", ctl(), 32'b000000);

      // clean restart after reset
      start = 1'b1;
      tick();
      start = 1'b0;
      check("post_rst_load", ctl(), 32'b110001);
      tick();
      pc_addr = 6'd5;
      fetch(32'h0000_0000);
      tick();
      check("post_rst_nop", ctl(), 32'b101001);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
